// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, derived totals/region bounds and the
// sync-decoder FSM state type; imported by the VGA generator and decoder.
package vga_timing_pkg;

   localparam int VGA_H_VIS  = 640;
   localparam int VGA_H_FP   = 16;
   localparam int VGA_H_SYNC = 96;
   localparam int VGA_H_BP   = 48;
   localparam int VGA_V_VIS  = 480;
   localparam int VGA_V_FP   = 10;
   localparam int VGA_V_SYNC = 2;
   localparam int VGA_V_BP   = 33;

   localparam int VGA_H_TOTAL = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int VGA_V_TOTAL = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   // Pixel region measured from the sync start: sync, back porch, then visible.
   localparam int VGA_H_PIX_FIRST = VGA_H_SYNC + VGA_H_BP;
   localparam int VGA_H_PIX_LAST  = VGA_H_PIX_FIRST + VGA_H_VIS - 1;
   localparam int VGA_V_PIX_FIRST = VGA_V_SYNC + VGA_V_BP;
   localparam int VGA_V_PIX_LAST  = VGA_V_PIX_FIRST + VGA_V_VIS - 1;

   localparam int                CNT_W   = 10;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_SEARCH,
      ST_MEASURE,
      ST_LOCKED
   } sync_state_e;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Registers one sync input, normalises its polarity and emits a registered
// one-cycle pulse on each transition into the active level.
module vga_sync_edge #(
   parameter bit SYNC_POL = 1'b0
) (
   input  logic clk_25mhz,
   input  logic rst_n,
   input  logic sync,
   output logic start
);

   logic act;
   logic act_q;

   assign act = (sync == SYNC_POL);

   // Registered copy resets to "active" so a sync already asserted when reset
   // releases is not mistaken for a fresh start.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_25mhz or negedge rst_n) begin
      if (!rst_n) begin
         act_q <= 1'b1;
         start <= 1'b0;
      end else begin
         act_q <= act;
         start <= act && !act_q;
      end
   end

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers x/y/de/frame_start from an hsync/vsync pair and locks onto the
// configured timing. Define VGA_SYNC_DECODER_STATS_EN to add err_cnt/meas_* ports.
module vga_sync_decoder
   import vga_timing_pkg::*;
#(
   parameter int H_VIS    = VGA_H_VIS,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_VIS    = VGA_V_VIS,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic             clk_25mhz,
   input  logic             rst_n,
   input  logic             hsync,
   input  logic             vsync,
   output logic [CNT_W-1:0] x,
   output logic [CNT_W-1:0] y,
   output logic             de,
   output logic             frame_start,
   output logic             locked,
   output logic             sync_err
`ifdef VGA_SYNC_DECODER_STATS_EN
   ,
   output logic [7:0]       err_cnt,
   output logic [CNT_W-1:0] meas_h_total,
   output logic [CNT_W-1:0] meas_v_total
`endif
);

   localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
   localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
   localparam logic [CNT_W-1:0] H_PIX_FIRST = CNT_W'(H_SYNC + H_BP);
   localparam logic [CNT_W-1:0] H_PIX_LAST  = CNT_W'(H_SYNC + H_BP + H_VIS - 1);
   localparam logic [CNT_W-1:0] V_PIX_FIRST = CNT_W'(V_SYNC + V_BP);
   localparam logic [CNT_W-1:0] V_PIX_LAST  = CNT_W'(V_SYNC + V_BP + V_VIS - 1);

   logic             hs_start;
   logic             vs_start;
   logic [CNT_W-1:0] hcnt;
   logic [CNT_W-1:0] vcnt;
   logic             vpend;
   sync_state_e      state;
   sync_state_e      state_nx;
   logic             vline;
   logic             line_bad;
   logic             frame_bad;
   logic             watchdog;
   logic             err;
   logic             fs_nx;
   logic             h_act;
   logic             v_act;

   vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_hs_edge (
      .clk_25mhz (clk_25mhz),
      .rst_n     (rst_n),
      .sync      (hsync),
      .start     (hs_start)
   );

   vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_vs_edge (
      .clk_25mhz (clk_25mhz),
      .rst_n     (rst_n),
      .sync      (vsync),
      .start     (vs_start)
   );

   // A line is vsync-qualified when a vsync start is pending or arrives with it.
   assign vline     = hs_start && (vpend || vs_start);
   assign line_bad  = hs_start && (hcnt != H_LAST);
   assign frame_bad = vline && (vcnt != V_LAST);
   assign watchdog  = (hcnt == CNT_MAX);

   always_ff @(posedge clk_25mhz or negedge rst_n) begin
      if (!rst_n) begin
         hcnt  <= '0;
         vcnt  <= '0;
         vpend <= 1'b0;
      end else begin
         hcnt <= hs_start ? '0 : sat_inc(hcnt);
         if (hs_start) begin
            vcnt  <= vline ? '0 : sat_inc(vcnt);
            vpend <= 1'b0;
         end else if (vs_start) begin
            vpend <= 1'b1;
         end
      end
   end

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_nx = state;
      err      = 1'b0;
      fs_nx    = 1'b0;
      unique case (state)
         ST_SEARCH: begin
            if (vs_start) state_nx = ST_SEARCH == ST_SEARCH ? ST_MEASURE : ST_SEARCH;
         end
         ST_MEASURE: begin
            if (line_bad || watchdog) begin
               err      = 1'b1;
               state_nx = ST_SEARCH;
            end else if (frame_bad) begin
               err = 1'b1;
            end else if (vline) begin
               state_nx = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            if (line_bad || frame_bad || watchdog) begin
               err      = 1'b1;
               state_nx = ST_SEARCH;
            end else if (vline) begin
               fs_nx = 1'b1;
            end
         end
         default: state_nx = ST_SEARCH;
      endcase
   end

   always_ff @(posedge clk_25mhz or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_SEARCH;
         sync_err    <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         state       <= state_nx;
         sync_err    <= err;
         frame_start <= fs_nx;
      end
   end

   // Outputs decode registered counters only; nothing combinational from the syncs.
   assign h_act  = (hcnt >= H_PIX_FIRST) && (hcnt <= H_PIX_LAST);
   assign v_act  = (vcnt >= V_PIX_FIRST) && (vcnt <= V_PIX_LAST);
   assign locked = (state == ST_LOCKED);
   assign de     = h_act && v_act && locked;
   assign x      = de ? hcnt - H_PIX_FIRST : '0;
   assign y      = de ? vcnt - V_PIX_FIRST : '0;

`ifdef VGA_SYNC_DECODER_STATS_EN
   always_ff @(posedge clk_25mhz or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt      <= '0;
         meas_h_total <= '0;
         meas_v_total <= '0;
      end else begin
         if (err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
         if (hs_start) meas_h_total <= hcnt + 1'b1;
         if (vline)    meas_v_total <= vcnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a scaled-down timing set
// (94 x 18 totals) so every scenario fits in a short run.
module tb_vga_sync_decoder;

   localparam int TH_VIS = 64, TH_FP = 8, TH_SYNC = 12, TH_BP = 10;
   localparam int TV_VIS = 10, TV_FP = 2, TV_SYNC = 2,  TV_BP = 4;
   localparam int H_TOTAL = TH_VIS + TH_FP + TH_SYNC + TH_BP;   // 94
   localparam int V_TOTAL = TV_VIS + TV_FP + TV_SYNC + TV_BP;   // 18
   localparam int FRAME   = H_TOTAL * V_TOTAL;                  // 1692
   localparam int HF = 22, HL = 85, VF = 6, VL = 15;            // pixel region bounds

   logic       clk_25mhz = 1'b0;
   logic       rst_n;
   logic       hsync;
   logic       vsync;
   logic [9:0] x;
   logic [9:0] y;
   logic       de;
   logic       frame_start;
   logic       locked;
   logic       sync_err;
`ifdef VGA_SYNC_DECODER_STATS_EN
   logic [7:0] err_cnt;
   logic [9:0] meas_h_total;
   logic [9:0] meas_v_total;
`endif

   vga_sync_decoder #(
      .H_VIS(TH_VIS), .H_FP(TH_FP), .H_SYNC(TH_SYNC), .H_BP(TH_BP),
      .V_VIS(TV_VIS), .V_FP(TV_FP), .V_SYNC(TV_SYNC), .V_BP(TV_BP),
      .SYNC_POL(1'b0)
   ) dut (
      .clk_25mhz   (clk_25mhz),
      .rst_n       (rst_n),
      .hsync       (hsync),
      .vsync       (vsync),
      .x           (x),
      .y           (y),
      .de          (de),
      .frame_start (frame_start),
      .locked      (locked),
      .sync_err    (sync_err)
`ifdef VGA_SYNC_DECODER_STATS_EN
      ,
      .err_cnt      (err_cnt),
      .meas_h_total (meas_h_total),
      .meas_v_total (meas_v_total)
`endif
   );

   always #5 clk_25mhz = ~clk_25mhz;

   int n_checks = 0;
   int n_fail   = 0;

   // Generator position of the next pixel to drive, plus per-line/frame lengths.
   int gh = 40, gv = V_TOTAL - 3;
   int line_len = H_TOTAL, frame_len = V_TOTAL;
   bit hold_h = 1'b0, vs_every = 1'b0, chk_en = 1'b0;
   int gh_d1 = 0, gv_d1 = 0, gh_d2 = 0, gv_d2 = 0;
   int samp = 0, vs_drives = 0, last_vs_samp = 0;
   int err_seen = 0, fs_seen = 0, de_seen = 0, err_samp = 0;
   logic err_locked = 1'b1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Sample outputs on the falling edge, then drive the next generator pixel.
   // Decoder outputs at a sample correspond to the pixel driven two samples earlier.
   task automatic pixel();
      bit in_reg;
      @(negedge clk_25mhz);
      samp++;
      if (sync_err === 1'b1) begin
         err_seen++;
         err_samp   = samp;
         err_locked = locked;
      end
      if (frame_start === 1'b1) fs_seen++;
      if (de === 1'b1) de_seen++;
      if (chk_en) begin
         in_reg = (gh_d2 >= HF) && (gh_d2 <= HL) && (gv_d2 >= VF) && (gv_d2 <= VL);
         check("locked_hold", locked, 1);
         check("no_sync_err", sync_err, 0);
         check("de", de, in_reg);
         check("x", x, in_reg ? gh_d2 - HF : 0);
         check("y", y, in_reg ? gv_d2 - VF : 0);
         check("frame_start", frame_start, (gh_d2 == 0) && (gv_d2 == 0));
      end
      hsync = (gh < TH_SYNC && !hold_h) ? 1'b0 : 1'b1;
      vsync = (vs_every ? (gh < TH_SYNC) : (gv < TV_SYNC)) ? 1'b0 : 1'b1;
      if (gh == 0 && gv == 0 && !vs_every) begin
         vs_drives++;
         last_vs_samp = samp;
      end
      gh_d2 = gh_d1; gv_d2 = gv_d1;
      gh_d1 = gh;    gv_d1 = gv;
      gh++;
      if (gh >= line_len) begin
         gh = 0;
         line_len = H_TOTAL;
         gv++;
         if (gv >= frame_len) begin
            gv = 0;
            frame_len = V_TOTAL;
         end
      end
   endtask

   task automatic run(input int n);
      repeat (n) pixel();
   endtask

   task automatic goto(input int v, input int h);
      int n;
      n = 0;
      while (!(gv == v && gh == h) && n < 4 * FRAME) begin
         pixel();
         n++;
      end
      if (n >= 4 * FRAME) check("goto_timeout", 0, 1);
   endtask

   // Lock must come exactly two vsyncs later, two samples after the vsync pixel.
   task automatic wait_lock(input string tag);
      int n, vs0, e0;
      n = 0; vs0 = vs_drives; e0 = err_seen;
      while (locked !== 1'b1 && n < 4 * FRAME) begin
         pixel();
         n++;
      end
      if (n >= 4 * FRAME) begin
         check({tag, "_lock_timeout"}, 0, 1);
      end else begin
         check({tag, "_lock_vsyncs"}, vs_drives - vs0, 2);
         check({tag, "_lock_delay"}, samp - last_vs_samp, 2);
         check({tag, "_no_err"}, err_seen - e0, 0);
      end
   endtask

   task automatic nominal_frame(input string tag);
      goto(0, 0);
      de_seen = 0; fs_seen = 0;
      chk_en = 1'b1;
      run(FRAME);
      chk_en = 1'b0;
      check({tag, "_de_cycles"}, de_seen, TH_VIS * TV_VIS);
      check({tag, "_frame_starts"}, fs_seen, 1);
   endtask

   initial begin
      int e0, f0, s0;
      rst_n = 1'b0;
      hsync = 1'b1;
      vsync = 1'b1;
      run(5);
      check("rst_x", x, 0);
      check("rst_y", y, 0);
      check("rst_de", de, 0);
      check("rst_frame_start", frame_start, 0);
      check("rst_locked", locked, 0);
      check("rst_sync_err", sync_err, 0);
`ifdef VGA_SYNC_DECODER_STATS_EN
      check("rst_err_cnt", err_cnt, 0);
`endif
      rst_n = 1'b1;

      wait_lock("init");
`ifdef VGA_SYNC_DECODER_STATS_EN
      check("meas_h_total", meas_h_total, H_TOTAL);
      check("meas_v_total", meas_v_total, V_TOTAL);
`endif
      nominal_frame("frame1");
      nominal_frame("frame2");

      // One line lengthened by a pixel.
      goto(5, 0);
      line_len = H_TOTAL + 1;
      e0 = err_seen; err_locked = 1'b1;
      run(2 * H_TOTAL);
      check("longline_err_pulses", err_seen - e0, 1);
      check("longline_locked_at_err", err_locked, 0);
      check("longline_locked_after", locked, 0);
      wait_lock("longline");

      // hsync held inactive: watchdog fires when hcnt reaches 1023.
      goto(2, 0);
      hold_h = 1'b1;
      e0 = err_seen; s0 = samp; err_locked = 1'b1;
      run(1100);
      hold_h = 1'b0;
      check("wd_err_pulses", err_seen - e0, 1);
      check("wd_err_time", err_samp - s0, 933);
      check("wd_locked_at_err", err_locked, 0);
      check("wd_locked_after", locked, 0);
      wait_lock("wd");

      // One frame one line too long.
      goto(1, 0);
      frame_len = V_TOTAL + 1;
      e0 = err_seen; f0 = fs_seen; err_locked = 1'b1;
      run(18 * H_TOTAL + 5);
      check("longframe_err_pulses", err_seen - e0, 1);
      check("longframe_err_at_vline", err_samp - last_vs_samp, 2);
      check("longframe_no_frame_start", fs_seen - f0, 0);
      check("longframe_locked_at_err", err_locked, 0);
      check("longframe_locked_after", locked, 0);
`ifdef VGA_SYNC_DECODER_STATS_EN
      check("err_cnt_three", err_cnt, 3);
`endif
      wait_lock("longframe");

      // Asynchronous reset mid-line while displaying (hcnt = 50, x = 28).
      goto(8, 0);
      run(52);
      #7;
      check("prerst_de", de, 1);
      check("prerst_x", x, 28);
      rst_n = 1'b0;
      #1;
      check("arst_x", x, 0);
      check("arst_y", y, 0);
      check("arst_de", de, 0);
      check("arst_locked", locked, 0);
      check("arst_frame_start", frame_start, 0);
      check("arst_sync_err", sync_err, 0);
      run(3);
      rst_n = 1'b1;
      wait_lock("arst");
      nominal_frame("frame3");

`ifdef VGA_SYNC_DECODER_STATS_EN
      check("err_cnt_cleared", err_cnt, 0);
      vs_every = 1'b1;
      run(300 * H_TOTAL);
      vs_every = 1'b0;
      check("err_cnt_saturated", err_cnt, 255);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
